pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the 16-bit MISC-V core. Sits beside the decode stage and drives the PC, IF/ID and ID/EX register enables: inserts load-use bubbles, flushes IF/ID on a decode-stage jump, and freezes the pipeline while the memory stage waits on a multi-cycle access. Also keeps saturating stall and flush event counters for debug.

## Interface
- LU_STALL_CYCLES, default 1: bubbles inserted per load-use hazard (1..7).
- CNT_W, default 16: width of the event counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_rs1  in  3  decode source register 1, ir[8:6].
- id_rs2  in  3  decode source register 2, ir[11:9].
- id_uses_rs2  in  1  decode instruction reads rs2.
- id_jump  in  1  decode stage resolved a taken jump/branch this cycle.
- ex_rd  in  3  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_reg_write  in  1  instruction in EX writes a register.
- mem_req  in  1  memory stage has an access outstanding.
- mem_ready  in  1  memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- pc_sel_jump  out  1  select jump target (new_pc) for PC.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_write  out  1  ID/EX enable.
- idex_bubble  out  1  load control-zero bubble into ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles (load-use plus memory wait).
- flush_cnt  out  CNT_W  saturating count of flushes.

## Operation
- Register 0 is hard-wired zero. Hazards on address 0 are ignored.
- Load-use hazard (lu): ex_mem_read & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Memory busy (mb): mem_req & !mem_ready.
- FSM states: RUN, LU_STALL, MEM_WAIT.
- RUN:
  - No event: all enables 1; flush, bubble and pc_sel_jump 0.
  - mb: freeze. pc_write=ifid_write=idex_write=0. Next state MEM_WAIT.
  - else lu: pc_write=ifid_write=0, idex_bubble=1, idex_write=1. Load counter with LU_STALL_CYCLES-1. Next state LU_STALL if LU_STALL_CYCLES>1, else RUN.
  - else id_jump: pc_write=1, pc_sel_jump=1, ifid_flush=1. Next state RUN.
- LU_STALL: same outputs as the lu case. Counter decrements each cycle; return to RUN in the cycle the counter reaches 0. mb during LU_STALL overrides with freeze and the counter holds.
- MEM_WAIT: freeze each cycle while mb. When mem_ready=1: normal RUN evaluation that same cycle (lu/jump allowed), next state RUN.
- Priority: Reset > mb > lu > id_jump. A jump coincident with lu is deferred. It is re-evaluated once the stall ends, because IF/ID holds the jump instruction.
- Counters:
  - stall_cnt +1 on every cycle with pc_write=0.
  - flush_cnt +1 on every cycle with ifid_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset asserted (Reset=0): immediately, asynchronously, state=RUN, lu counter=0, stall_cnt=flush_cnt=0. Outputs are then decoded combinationally from RUN and the live inputs.
- Outputs are combinational from current state and inputs. The hazard response occurs in the same cycle as detection; there is zero-cycle latency.
- State and counters register on the CLK rising edge.
- A load-use hazard costs exactly LU_STALL_CYCLES cycles with pc_write=0.
- A jump costs exactly 1 flushed slot.
- A memory wait costs one freeze cycle per cycle with mem_ready=0 while mem_req=1.
- mem_ready without mem_req is ignored.
- Reset deasserted mid-stall: FSM resumes from RUN. No pending stall is remembered.

## Structure
- Shared package misc_v_pkg holds:
  - the state encoding constants (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2);
  - the register address width (3);
  - the zero register index.
- One sub-module is natural: sat_counter (parameter W, inc, async active-low clear), instantiated twice for the event counters.

## Test plan
- Reset: hold Reset=0 with random inputs. Expect stall_cnt=flush_cnt=0 and state RUN. Release Reset with quiet inputs; expect pc_write=ifid_write=idex_write=1.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs1=3, LU_STALL_CYCLES=1. Expect one cycle of pc_write=0, idex_bubble=1, then normal flow; stall_cnt=1. Repeat with ex_rd=0; expect no stall.
- Jump: id_jump=1 for one cycle. Expect pc_sel_jump=1 and ifid_flush=1 for that cycle; flush_cnt=1.
- Jump plus lu: both asserted together. Expect the bubble first and no flush. Next cycle, with id_jump still 1 and lu cleared, expect ifid_flush=1.
- Memory wait: mem_req=1 with mem_ready=0 for 4 cycles, then mem_ready=1. Expect 4 freeze cycles and stall_cnt=4. With LU_STALL_CYCLES=3 and mb in the 2nd stall cycle, expect the counter to hold and the stall to extend.
- Saturation: with CNT_W=4, apply 20 stall cycles. Expect stall_cnt=15 held, with no wrap.

Source files
------------

// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V pipeline sequencing logic: FSM encoding,
// register addressing and the per-cycle pipeline control word.
package misc_v_pkg;

  localparam int REG_AW = 3;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic pc_sel_jump;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = pipe_ctl_t'(6'b101010);
  localparam pipe_ctl_t CTL_FREEZE = pipe_ctl_t'(6'b000000);
  localparam pipe_ctl_t CTL_BUBBLE = pipe_ctl_t'(6'b000011);
  localparam pipe_ctl_t CTL_JUMP   = pipe_ctl_t'(6'b111110);

  // A load in EX feeding a source register of the instruction in decode.
  function automatic logic load_use(
    input logic              mem_read,
    input logic              reg_write,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2,
    input logic              uses_rs2
  );
    return mem_read && reg_write && (rd != ZERO_REG) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and pipeline enables of the sequencing controller.
// Inputs are level signals sampled every cycle; outputs are valid in the same cycle.
interface pipeline_hazard_ctrl_if
  import misc_v_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic              id_jump;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_write;
  logic              pc_sel_jump;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  hz_state_t         state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, id_jump, ex_rd, ex_mem_read,
           ex_reg_write, mem_req, mem_ready,
    input  pc_write, pc_sel_jump, ifid_write, ifid_flush, idex_write,
           idex_bubble, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, id_jump, ex_rd, ex_mem_read,
           ex_reg_write, mem_req, mem_ready,
    output pc_write, pc_sel_jump, ifid_write, ifid_flush, idex_write,
           idex_bubble, stall_cnt, flush_cnt, state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, decode-jump flush and
// memory-wait freeze, with saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import misc_v_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [2:0] LU_LOAD  = 3'(LU_STALL_CYCLES - 1);
  localparam logic       LU_MULTI = (LU_STALL_CYCLES > 1);

  hz_state_t  state, state_nxt;
  logic [2:0] lu_cnt, lu_cnt_nxt;
  pipe_ctl_t  ctl;
  logic       lu, mb;

  assign lu = load_use(hz.ex_mem_read, hz.ex_reg_write, hz.ex_rd,
                       hz.id_rs1, hz.id_rs2, hz.id_uses_rs2);
  assign mb = hz.mem_req && !hz.mem_ready;

  // MEM_WAIT only differs from RUN in how it was entered; once the access
  // completes the same cycle gets full RUN evaluation, so they share a branch.
  always_comb begin
    ctl        = CTL_RUN;
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    case (state)
      LU_STALL: begin
        if (mb) begin
          ctl = CTL_FREEZE;
        end else begin
          ctl = CTL_BUBBLE;
          if (lu_cnt <= 3'd1) begin
            lu_cnt_nxt = '0;
            state_nxt  = RUN;
          end else begin
            lu_cnt_nxt = lu_cnt - 3'd1;
          end
        end
      end
      default: begin
        if (mb) begin
          ctl       = CTL_FREEZE;
          state_nxt = MEM_WAIT;
        end else if (lu) begin
          ctl        = CTL_BUBBLE;
          lu_cnt_nxt = LU_LOAD;
          state_nxt  = LU_MULTI ? LU_STALL : RUN;
        end else if (hz.id_jump) begin
          ctl       = CTL_JUMP;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  assign hz.pc_write    = ctl.pc_write;
  assign hz.pc_sel_jump = ctl.pc_sel_jump;
  assign hz.ifid_write  = ctl.ifid_write;
  assign hz.ifid_flush  = ctl.ifid_flush;
  assign hz.idex_write  = ctl.idex_write;
  assign hz.idex_bubble = ctl.idex_bubble;
  assign hz.state       = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctl.pc_write),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.ifid_flush),
    .count (hz.flush_cnt)
  );

endmodule
